multiplier64_seq: RTL and testbench

- Multi-cycle 64-bit signed multiplier. It is the inverse-operation companion to the combinational 64-bit signed divider, and together they form the core's M-extension style mul/div unit.
- Produces the full 128-bit product (hi/lo) plus a signed-overflow flag. The overflow flag plays the role the divide-by-zero flag plays for the divider.
- Radix-2 shift-add on operand magnitudes with a sign fix-up. Fixed latency with a start/done handshake, so the single-cycle datapath can stall on it.

---
 rtl/multiplier64_seq.sv | 83 ++++++++
 tb/tb_multiplier64_seq.sv | 105 ++++++++++
 2 files changed

// File: rtl/multiplier64_seq.sv
// multiplier64_seq: multi-cycle signed radix-2 shift-add multiplier with full product and overflow flag
module multiplier64_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t             state, state_next;
  logic [WIDTH-1:0]   mcand, mplier, a_mag, b_mag;
  logic [2*WIDTH-1:0] acc, result;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      count;
  logic               neg, last;
  // magnitudes, one shift-add step and the signed fix-up of the finished accumulator
  always_comb begin
    a_mag  = a[WIDTH-1] ? -a : a;
    b_mag  = b[WIDTH-1] ? -b : b;
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    result = neg ? ~acc + 1'b1 : acc;
    last   = count == CW'(WIDTH - 1);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  // next-state and handshake outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: state_next = start ? RUN : IDLE;
      RUN: begin
        busy       = 1'b1;
        state_next = last ? FIX : RUN;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      default: begin
        done       = 1'b1;
        state_next = IDLE;
      end
    endcase
  end
  // datapath: operand capture, shift-add iterations and result registration
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      count      <= '0;
      neg        <= 1'b0;
      product_lo <= '0;
      product_hi <= '0;
      overflow   <= 1'b0;
    end else if (state == IDLE && start) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      neg    <= a[WIDTH-1] ^ b[WIDTH-1];
      acc    <= '0;
      count  <= '0;
    end else if (state == RUN) begin
      acc    <= {sum, acc[WIDTH-1:1]};
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
    end else if (state == FIX) begin
      product_hi <= result[2*WIDTH-1:WIDTH];
      product_lo <= result[WIDTH-1:0];
      overflow   <= result[2*WIDTH-1:WIDTH] != {WIDTH{result[WIDTH-1]}};
    end
endmodule

// File: tb/tb_multiplier64_seq.sv
// tb_multiplier64_seq: directed and random checks of multiplier64_seq against a plain arithmetic model
module tb_multiplier64_seq;
  localparam int W = 64;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, overflow;
  logic [W-1:0] product_lo, product_hi;
  int n_chk = 0, n_fail = 0;

  multiplier64_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .busy(busy), .done(done),
    .product_lo(product_lo), .product_hi(product_hi), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
      check("busy_while_running", 128'(busy), 128'(1));
    end
    if (!done) check("done_timeout", 128'(done), 128'(1));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [127:0] p;
    int cyc;
    p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
    kick(x, y);
    wait_done(cyc);
    check({tag, "_latency"}, 128'(cyc + 1), 128'(W + 2));
    check({tag, "_product"}, {product_hi, product_lo}, p);
    check({tag, "_overflow"}, 128'(overflow), 128'(p != {{W{p[W-1]}}, p[W-1:0]}));
    check({tag, "_busy_at_done"}, 128'(busy), 128'(0));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 128'(done), 128'(0));
  endtask

  initial begin
    int cyc;
    bit seen;
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_product", {product_hi, product_lo}, 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    run_op("7x-3", 64'd7, -64'sd3);
    check("7x-3_lo", 128'(product_lo), 128'hFFFF_FFFF_FFFF_FFEB);
    check("7x-3_hi", 128'(product_hi), 128'hFFFF_FFFF_FFFF_FFFF);
    run_op("min_x_m1", 64'h8000_0000_0000_0000, '1);
    check("min_x_m1_ovf", 128'(overflow), 128'(1));
    run_op("max_x_max", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
    check("max_x_max_hi", 128'(product_hi), 128'h3FFF_FFFF_FFFF_FFFF);
    run_op("min_x_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    check("min_x_min_hi", 128'(product_hi), 128'h4000_0000_0000_0000);
    run_op("zero_x_m5", 64'd0, -64'sd5);
    check("zero_x_m5_all", {127'(0), overflow} | {product_hi, product_lo}, 128'(0));
    for (int i = 0; i < 16; i++)
      run_op("random", {$urandom, $urandom}, (i % 4 == 0) ? 64'($signed($urandom_range(0, 40)) - 20) : {$urandom, $urandom});
    kick(64'd5, 64'd6);
    repeat (10) @(posedge clk);
    @(negedge clk); a = 64'd9; b = 64'd9; start = 1'b1;
    @(negedge clk); start = 1'b0; a = 64'd123; b = -64'sd77;
    wait_done(cyc);
    check("ignored_start_product", {product_hi, product_lo}, 128'd30);
    check("ignored_start_overflow", 128'(overflow), 128'(0));
    @(posedge clk); #1;
    kick(64'd5, 64'd6);
    repeat (20) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    check("midrun_rst_product", {product_hi, product_lo}, 128'(0));
    check("midrun_rst_busy", 128'(busy), 128'(0));
    check("midrun_rst_done", 128'(done), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      seen |= done;
    end
    check("midrun_rst_no_done", 128'(seen), 128'(0));
    run_op("after_rst_2x3", 64'd2, 64'd3);
    check("after_rst_lo", 128'(product_lo), 128'd6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
